// File: rtl/rram_phase_seq_if.sv
// Handshake and tile-drive bundle between the training controller and rram_phase_seq.
// RRAM_ABORT_EN adds the controller-driven abort line.
interface rram_phase_seq_if #(
  parameter int ROWS = 12,
  parameter int COLS = 12
);
  logic            start;
  logic [ROWS-1:0] ff_row_mask;
  logic [ROWS-1:0] wl;
  logic [ROWS-1:0] sl;
  logic [COLS-1:0] bl;
  logic            set;
  logic            back;
  logic            label;
  logic            busy;
  logic            done;
  logic [2:0]      phase;
`ifdef RRAM_ABORT_EN
  logic            abort;

  modport master (output start, ff_row_mask, abort,
                  input  wl, sl, bl, set, back, label, busy, done, phase);
  modport slave  (input  start, ff_row_mask, abort,
                  output wl, sl, bl, set, back, label, busy, done, phase);
`else
  modport master (output start, ff_row_mask,
                  input  wl, sl, bl, set, back, label, busy, done, phase);
  modport slave  (input  start, ff_row_mask,
                  output wl, sl, bl, set, back, label, busy, done, phase);
`endif
endinterface

// File: rtl/rram_phase_seq.sv
// Training-pass sequencer for one RRAM crossbar tile: WL enable, SET, feed-forward, error, thermometer update.
// Optional feature macro RRAM_ABORT_EN: abort input forces an in-progress pass straight to DONE.
module rram_phase_seq #(
  parameter int ROWS      = 12,
  parameter int COLS      = 12,
  parameter int PHASE_CYC = 10,
  parameter int UPD_INC   = 4,
  parameter int CNT_W     = 8
) (
  input logic          clk,
  input logic          rst_n,
  rram_phase_seq_if.slave bus
);
  localparam int                 N_STEP   = (COLS + UPD_INC - 1) / UPD_INC;
  localparam int                 K_W      = $clog2(N_STEP + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [K_W-1:0]     K_LAST   = K_W'(N_STEP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WL_ON   = 3'd1,
    INIT    = 3'd2,
    FEED    = 3'd3,
    ERR     = 3'd4,
    UPDATE  = 3'd5,
    UPD_END = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [K_W-1:0]   r_k, w_k;
  logic [ROWS-1:0]  r_mask, w_mask;
  logic [ROWS-1:0]  r_wl, w_wl, r_sl, w_sl;
  logic [COLS-1:0]  r_bl, w_bl;
  logic             r_set, w_set, r_back, w_back, r_label, w_label;
  logic             r_busy, w_busy, r_done, w_done;
  logic             w_step_end, w_abort;

  // Sub-step k drives min((k+1)*UPD_INC, COLS) low bitlines; the last sub-step releases them all.
  function automatic logic [COLS-1:0] therm(input logic [K_W-1:0] k);
    logic [COLS-1:0] t;
    int              lim;
    t   = '0;
    lim = (int'(k) + 1) * UPD_INC;
    if (k != K_LAST) begin
      for (int i = 0; i < COLS; i++) t[i] = (i < lim);
    end
    return t;
  endfunction

`ifdef RRAM_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_step_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_k     = r_k;
    w_mask  = r_mask;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state = WL_ON;
          w_mask  = bus.ff_row_mask;
          w_cnt   = '0;
          w_k     = '0;
        end
      end
      DONE: w_state = IDLE;
      default: begin
        if (w_abort) begin
          w_state = DONE;
          w_cnt   = '0;
          w_k     = '0;
        end else if (!w_step_end) begin
          w_cnt = r_cnt + 1'b1;
        end else begin
          w_cnt = '0;
          case (r_state)
            WL_ON:   w_state = INIT;
            INIT:    w_state = FEED;
            FEED:    w_state = ERR;
            ERR: begin
              w_state = UPDATE;
              w_k     = '0;
            end
            UPDATE: begin
              if (r_k == K_LAST) w_state = UPD_END;
              else               w_k     = r_k + 1'b1;
            end
            UPD_END: w_state = DONE;
            default: w_state = IDLE;
          endcase
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the transition.
  always_comb begin
    w_wl    = '0;
    w_sl    = '0;
    w_bl    = '0;
    w_set   = 1'b0;
    w_back  = 1'b0;
    w_label = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (w_state)
      WL_ON: begin
        w_wl   = '1;
        w_busy = 1'b1;
      end
      INIT: begin
        w_wl   = '1;
        w_set  = 1'b1;
        w_bl   = '1;
        w_busy = 1'b1;
      end
      FEED: begin
        w_wl   = '1;
        w_sl   = w_mask;
        w_busy = 1'b1;
      end
      ERR, UPD_END: begin
        w_wl    = '1;
        w_sl    = w_mask;
        w_label = 1'b1;
        w_busy  = 1'b1;
      end
      UPDATE: begin
        w_wl    = '1;
        w_sl    = w_mask;
        w_label = 1'b1;
        w_back  = 1'b1;
        w_bl    = therm(w_k);
        w_busy  = 1'b1;
      end
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_mask  <= '0;
      r_wl    <= '0;
      r_sl    <= '0;
      r_bl    <= '0;
      r_set   <= 1'b0;
      r_back  <= 1'b0;
      r_label <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_k     <= w_k;
      r_mask  <= w_mask;
      r_wl    <= w_wl;
      r_sl    <= w_sl;
      r_bl    <= w_bl;
      r_set   <= w_set;
      r_back  <= w_back;
      r_label <= w_label;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.wl    = r_wl;
  assign bus.sl    = r_sl;
  assign bus.bl    = r_bl;
  assign bus.set   = r_set;
  assign bus.back  = r_back;
  assign bus.label = r_label;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.phase = r_state;
endmodule
